// File: rtl/sdr_dq_pipe.sv
// SDRAM DQ datapath: delays host write data/masks to the DQ pins and captures read bursts.
// Latency: write WR_LAT cycles; read first beat at RD_CMD+CAS_LAT+1 (+1 with SDR_RD_OUT_REG_EN).
// Backpressure: none; the controller schedules commands and COLLIDE flags write/read overlap.
module sdr_dq_pipe #(
    parameter int DSIZE     = 32,
    parameter int WR_LAT    = 2,
    parameter int CAS_LAT   = 2,
    parameter int BURST_LEN = 1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [DSIZE-1:0]   DATAIN,
    input  logic [DSIZE/8-1:0] DM,
    input  logic               WR_EN,
    output logic [DSIZE-1:0]   DQOUT,
    output logic [DSIZE/8-1:0] DQM,
    output logic               DQ_OE,
    input  logic               RD_CMD,
    input  logic [DSIZE-1:0]   DQIN,
    output logic [DSIZE-1:0]   RD_DATA,
    output logic               RD_VALID,
    output logic               RD_BUSY,
    output logic               COLLIDE
);

    localparam int MW = DSIZE / 8;
    localparam int CW = $clog2(BURST_LEN + 1);

    // Write pipe: data, mask and valid travel together so they stay aligned.
    logic [DSIZE-1:0] wr_dat [WR_LAT];
    logic [MW-1:0]    wr_msk [WR_LAT];
    logic [WR_LAT-1:0] wr_vld;

    // Read pipe: command delay line, burst counter and capture register.
    logic [CAS_LAT-1:0] rd_pipe;
    logic [CW-1:0]      burst_cnt;
    logic [CW-1:0]      eff_cnt;
    logic               cap;
    logic [DSIZE-1:0]   cap_dat;
    logic               cap_vld;
    logic               collide_r;

    // Shift write beats toward the DQ pins; masks are zeroed for idle beats at entry.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < WR_LAT; i++) begin
                wr_dat[i] <= '0;
                wr_msk[i] <= '0;
            end
            wr_vld <= '0;
        end else begin
            wr_dat[0] <= DATAIN;
            wr_msk[0] <= WR_EN ? DM : '0;
            wr_vld[0] <= WR_EN;
            for (int i = 1; i < WR_LAT; i++) begin
                wr_dat[i] <= wr_dat[i-1];
                wr_msk[i] <= wr_msk[i-1];
                wr_vld[i] <= wr_vld[i-1];
            end
        end
    end

    assign DQOUT = wr_dat[WR_LAT-1];
    assign DQM   = wr_msk[WR_LAT-1];
    assign DQ_OE = wr_vld[WR_LAT-1];

    // A delayed command (re)loads the burst length; otherwise the running count is used.
    always_comb begin
        eff_cnt = burst_cnt;
        if (rd_pipe[CAS_LAT-1]) begin
            eff_cnt = CW'(BURST_LEN);
        end
        cap = (eff_cnt != '0);
    end

    // Delay read commands by CAS latency and count down the beats of the active burst.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_pipe   <= '0;
            burst_cnt <= '0;
        end else begin
            rd_pipe[0] <= RD_CMD;
            for (int i = 1; i < CAS_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            burst_cnt <= cap ? eff_cnt - CW'(1) : '0;
        end
    end

    // Capture DQ for every counted beat; data holds between beats.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cap_dat <= '0;
            cap_vld <= 1'b0;
        end else begin
            cap_vld <= cap;
            if (cap) begin
                cap_dat <= DQIN;
            end
        end
    end

    // Sticky flag: a write beat on the pins while a read beat is being captured.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            collide_r <= 1'b0;
        end else if (wr_vld[WR_LAT-1] && cap_vld) begin
            collide_r <= 1'b1;
        end
    end

    assign COLLIDE = collide_r;

`ifdef SDR_RD_OUT_REG_EN
    logic [DSIZE-1:0] out_dat;
    logic             out_vld;

    // Extra output stage for timing closure toward the host.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_dat <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= cap_vld;
            if (cap_vld) begin
                out_dat <= cap_dat;
            end
        end
    end

    assign RD_DATA  = out_dat;
    assign RD_VALID = out_vld;
    assign RD_BUSY  = (|rd_pipe) || (burst_cnt != '0) || cap_vld;
`else
    assign RD_DATA  = cap_dat;
    assign RD_VALID = cap_vld;
    assign RD_BUSY  = (|rd_pipe) || (burst_cnt != '0);
`endif

endmodule

// File: tb/tb_sdr_dq_pipe.sv
// Directed bench for sdr_dq_pipe: write delay, read bursts, chaining, collision, reset.
// Cycle c begins at posedge c; inputs change 1ns after the edge, outputs sampled at negedge.
// Two instances share stimulus: BURST_LEN=4 (u_dut) and BURST_LEN=2 (u_dut2).
module tb_sdr_dq_pipe;

`ifdef SDR_RD_OUT_REG_EN
    localparam int RX = 1;
`else
    localparam int RX = 0;
`endif

    logic        CLK;
    logic        RESET_N;
    logic [31:0] DATAIN;
    logic [3:0]  DM;
    logic        WR_EN;
    logic        RD_CMD;
    logic [31:0] DQIN;

    logic [31:0] DQOUT, RD_DATA;
    logic [3:0]  DQM;
    logic        DQ_OE, RD_VALID, RD_BUSY, COLLIDE;

    logic [31:0] dqout2, rd_data2;
    logic [3:0]  dqm2;
    logic        dq_oe2, rd_valid2, rd_busy2, collide2;

    int total = 0;
    int bad   = 0;

    sdr_dq_pipe #(.DSIZE(32), .WR_LAT(2), .CAS_LAT(2), .BURST_LEN(4)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .DATAIN(DATAIN), .DM(DM), .WR_EN(WR_EN),
        .DQOUT(DQOUT), .DQM(DQM), .DQ_OE(DQ_OE), .RD_CMD(RD_CMD), .DQIN(DQIN),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_BUSY(RD_BUSY), .COLLIDE(COLLIDE)
    );

    sdr_dq_pipe #(.DSIZE(32), .WR_LAT(2), .CAS_LAT(2), .BURST_LEN(2)) u_dut2 (
        .CLK(CLK), .RESET_N(RESET_N), .DATAIN(DATAIN), .DM(DM), .WR_EN(WR_EN),
        .DQOUT(dqout2), .DQM(dqm2), .DQ_OE(dq_oe2), .RD_CMD(RD_CMD), .DQIN(DQIN),
        .RD_DATA(rd_data2), .RD_VALID(rd_valid2), .RD_BUSY(rd_busy2), .COLLIDE(collide2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        DATAIN = '0;
        DM     = '0;
        WR_EN  = 1'b0;
        RD_CMD = 1'b0;
        DQIN   = 32'hDEAD_BEEF;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET_N = 1'b0;
        next_cycle();
        next_cycle();
        RESET_N = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET_N = 1'b0;
        next_cycle();
        @(negedge CLK);
        total++;
        if ({DQOUT, DQM, DQ_OE, RD_DATA, RD_VALID, RD_BUSY, COLLIDE} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got dqout=%h dqm=%b oe=%b rd=%h vld=%b busy=%b col=%b, need all 0",
                     DQOUT, DQM, DQ_OE, RD_DATA, RD_VALID, RD_BUSY, COLLIDE);
        end
        next_cycle();
        RESET_N = 1'b1;
        next_cycle();
    endtask

    task automatic test_write();
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            if (c == 0) begin
                WR_EN  = 1'b1;
                DATAIN = 32'hA5A5_0001;
                DM     = 4'b0010;
            end
            @(negedge CLK);
            total++;
            if (DQ_OE !== (c == 2)) begin
                bad++;
                $display("FAIL write_oe c=%0d: got %b need %b", c, DQ_OE, (c == 2));
            end
            total++;
            if (DQM !== ((c == 2) ? 4'b0010 : 4'b0000)) begin
                bad++;
                $display("FAIL write_dqm c=%0d: got %b", c, DQM);
            end
            if (c == 2) begin
                total++;
                if (DQOUT !== 32'hA5A5_0001) begin
                    bad++;
                    $display("FAIL write_data: got %h need a5a50001", DQOUT);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back_write();
        logic [31:0] exp_d [3];
        logic [3:0]  exp_m [3];
        exp_d[0] = 32'h1111_2222; exp_m[0] = 4'b1111;
        exp_d[1] = 32'h3333_4444; exp_m[1] = 4'b0001;
        exp_d[2] = 32'h5555_6666; exp_m[2] = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            if (c < 3) begin
                DATAIN = exp_d[c];
                DM     = (c == 2) ? 4'b1111 : exp_m[c];
                WR_EN  = (c < 2);
            end
            @(negedge CLK);
            if (c >= 2 && c <= 4) begin
                total++;
                if (DQOUT !== exp_d[c-2] || DQM !== exp_m[c-2] || DQ_OE !== (c < 4)) begin
                    bad++;
                    $display("FAIL b2b_write c=%0d: got d=%h m=%b oe=%b need d=%h m=%b oe=%b",
                             c, DQOUT, DQM, DQ_OE, exp_d[c-2], exp_m[c-2], (c < 4));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_read_burst();
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            if (c == 0) RD_CMD = 1'b1;
            if (c >= 2 && c <= 5) DQIN = 32'(c - 1);
            @(negedge CLK);
            total++;
            if (RD_VALID !== (c >= 3 + RX && c <= 6 + RX)) begin
                bad++;
                $display("FAIL read_valid c=%0d: got %b", c, RD_VALID);
            end
            if (c >= 3 + RX && c <= 6 + RX) begin
                total++;
                if (RD_DATA !== 32'(c - 2 - RX)) begin
                    bad++;
                    $display("FAIL read_data c=%0d: got %h need %h", c, RD_DATA, 32'(c - 2 - RX));
                end
            end
            if (c == 8) begin
                total++;
                if (RD_DATA !== 32'd4) begin
                    bad++;
                    $display("FAIL read_hold: got %h need 4", RD_DATA);
                end
            end
            total++;
            if (RD_BUSY !== (c >= 1 && c <= 5 + RX)) begin
                bad++;
                $display("FAIL read_busy c=%0d: got %b", c, RD_BUSY);
            end
            next_cycle();
        end
    endtask

    task automatic test_chain();
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            if (c == 0 || c == 2) RD_CMD = 1'b1;
            DQIN = 32'(10 + c);
            @(negedge CLK);
            total++;
            if (rd_valid2 !== (c >= 3 + RX && c <= 6 + RX)) begin
                bad++;
                $display("FAIL chain_valid c=%0d: got %b", c, rd_valid2);
            end
            if (c >= 3 + RX && c <= 6 + RX) begin
                total++;
                if (rd_data2 !== 32'(9 + c - RX)) begin
                    bad++;
                    $display("FAIL chain_data c=%0d: got %0d need %0d", c, rd_data2, 9 + c - RX);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_collide();
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            if (c == 0) RD_CMD = 1'b1;
            if (c == 1) begin
                WR_EN  = 1'b1;
                DATAIN = 32'hCAFE_0000;
            end
            @(negedge CLK);
            total++;
            if (COLLIDE !== (c >= 4)) begin
                bad++;
                $display("FAIL collide c=%0d: got %b need %b", c, COLLIDE, (c >= 4));
            end
            next_cycle();
        end
        do_reset();
        @(negedge CLK);
        total++;
        if (COLLIDE !== 1'b0) begin
            bad++;
            $display("FAIL collide_clear: got %b need 0", COLLIDE);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        for (int c = 0; c < 11; c++) begin
            idle_inputs();
            RESET_N = (c != 4);
            if (c == 0) RD_CMD = 1'b1;
            if (c == 3) begin
                WR_EN  = 1'b1;
                DATAIN = 32'h0BAD_F00D;
                DM     = 4'b1010;
            end
            DQIN = 32'(c + 1);
            if (c == 4) begin
                #1;
                total++;
                if ({DQOUT, DQM, DQ_OE, RD_DATA, RD_VALID, RD_BUSY, COLLIDE} !== '0) begin
                    bad++;
                    $display("FAIL midreset_outputs: got rd=%h vld=%b busy=%b oe=%b",
                             RD_DATA, RD_VALID, RD_BUSY, DQ_OE);
                end
            end
            @(negedge CLK);
            if (c == 3) begin
                total++;
                if (RD_BUSY !== 1'b1) begin
                    bad++;
                    $display("FAIL midreset_prebusy: got %b need 1", RD_BUSY);
                end
            end
            if (c >= 5) begin
                total++;
                if (RD_VALID !== 1'b0 || DQ_OE !== 1'b0 || RD_BUSY !== 1'b0) begin
                    bad++;
                    $display("FAIL midreset_after c=%0d: got vld=%b oe=%b busy=%b need 0",
                             c, RD_VALID, DQ_OE, RD_BUSY);
                end
            end
            next_cycle();
        end
        RESET_N = 1'b1;
    endtask

    initial begin
        idle_inputs();
        RESET_N = 1'b0;
        #2;
        test_reset();
        test_write();
        do_reset();
        test_back_to_back_write();
        do_reset();
        test_read_burst();
        do_reset();
        test_chain();
        do_reset();
        test_collide();
        do_reset();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
